// File: rtl/rob_alloc_if.sv
// Decode-side allocation / ROB-side retirement handshake for the ROB slot allocator.
interface rob_alloc_if #(
   parameter int IDX_BITS = 4
);
   logic                clear;
   logic                alloc_req;
   logic                alloc_grant;
   logic [IDX_BITS-1:0] alloc_idx;
   logic                stall;
   logic                retire;
   logic [IDX_BITS-1:0] retire_idx;
   logic [IDX_BITS:0]   count;
   logic                full;
   logic                empty;
   logic                err;

   modport master (
      output clear, alloc_req, retire, retire_idx,
      input  alloc_grant, alloc_idx, stall, count, full, empty, err
   );

   modport slave (
      input  clear, alloc_req, retire, retire_idx,
      output alloc_grant, alloc_idx, stall, count, full, empty, err
   );
endinterface

// File: rtl/rob_alloc.sv
// ROB slot allocator: hands out slot indices in program order at decode and
// reclaims them as the ROB retires its head, stalling decode when all slots are in flight.
module rob_alloc #(
   parameter int SLOTS    = 16,
   parameter int IDX_BITS = 4
) (
   input  logic        clk,
   input  logic        rst,
   rob_alloc_if.slave  bus
);
   localparam logic [IDX_BITS:0]   CNT_FULL = (IDX_BITS+1)'(SLOTS);
   localparam logic [IDX_BITS:0]   CNT_ONE  = (IDX_BITS+1)'(1);
   localparam logic [IDX_BITS-1:0] IDX_ONE  = IDX_BITS'(1);

   logic [IDX_BITS-1:0] tail_q, tail_d;
   logic [IDX_BITS-1:0] head_q, head_d;
   logic [IDX_BITS:0]   count_q, count_d;
   logic                err_q, err_d;

   logic full, empty, grant, retire_ok;

   // full/empty come only from the registered count, so a retire never frees
   // a slot for a grant in the same cycle.
   always_comb begin
      full      = (count_q == CNT_FULL);
      empty     = (count_q == '0);
      grant     = bus.alloc_req && !full && !bus.clear && !rst;
      retire_ok = bus.retire && !empty;

      tail_d  = tail_q;
      head_d  = head_q;
      count_d = count_q;
      err_d   = err_q;

      if (bus.clear) begin
         tail_d  = '0;
         head_d  = '0;
         count_d = '0;
      end else begin
         if (grant)     tail_d = tail_q + IDX_ONE;
         if (retire_ok) head_d = head_q + IDX_ONE;
         case ({grant, retire_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
         // The ROB's order is authoritative: a mismatched index still advances head.
         if (bus.retire && empty)                      err_d = 1'b1;
         if (retire_ok && (bus.retire_idx != head_q))  err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tail_q  <= '0;
         head_q  <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         tail_q  <= tail_d;
         head_q  <= head_d;
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

   assign bus.alloc_grant = grant;
   assign bus.alloc_idx   = tail_q;
   assign bus.stall       = bus.alloc_req && !grant;
   assign bus.count       = count_q;
   assign bus.full        = full;
   assign bus.empty       = empty;
   assign bus.err         = err_q;
endmodule

// File: tb/tb_rob_alloc.sv
// Directed bench for rob_alloc: fill/stall, retire-from-full, wrap, clear, and error flag.
module tb_rob_alloc;
   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   rob_alloc_if #(.IDX_BITS(4)) bus ();
   rob_alloc #(.SLOTS(16), .IDX_BITS(4)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Drive one cycle's inputs mid low-phase, then let combinational outputs settle.
   task automatic step(input logic r, input logic c, input logic ar,
                       input logic rt, input int ri);
      @(negedge clk);
      rst            = r;
      bus.clear      = c;
      bus.alloc_req  = ar;
      bus.retire     = rt;
      bus.retire_idx = 4'(ri);
      #1;
   endtask

   initial begin
      rst = 1'b1; bus.clear = 1'b0; bus.alloc_req = 1'b0;
      bus.retire = 1'b0; bus.retire_idx = '0;
      step(1, 0, 1, 0, 0);
      chk("grant_in_rst", int'(bus.alloc_grant), 0);
      step(1, 0, 0, 0, 0);
      chk("rst_count", int'(bus.count), 0);
      chk("rst_empty", int'(bus.empty), 1);
      chk("rst_full",  int'(bus.full), 0);
      chk("rst_idx",   int'(bus.alloc_idx), 0);
      chk("rst_err",   int'(bus.err), 0);

      // 1: fill all 16 slots
      for (int i = 0; i < 16; i++) begin
         step(0, 0, 1, 0, 0);
         chk("fill_grant", int'(bus.alloc_grant), 1);
         chk("fill_idx",   int'(bus.alloc_idx), i);
         chk("fill_stall", int'(bus.stall), 0);
      end
      step(0, 0, 1, 0, 0);
      chk("full_count", int'(bus.count), 16);
      chk("full_flag",  int'(bus.full), 1);
      chk("full_grant", int'(bus.alloc_grant), 0);
      chk("full_stall", int'(bus.stall), 1);

      // 2: retire from full does not free a slot the same cycle
      step(0, 0, 1, 1, 0);
      chk("rf_grant", int'(bus.alloc_grant), 0);
      chk("rf_stall", int'(bus.stall), 1);
      step(0, 0, 1, 0, 0);
      chk("rf_count", int'(bus.count), 15);
      chk("rf_grant_next", int'(bus.alloc_grant), 1);
      chk("rf_idx_next",   int'(bus.alloc_idx), 0);
      step(0, 0, 0, 1, 1);
      chk("rf_count_refill", int'(bus.count), 16);
      // head=2, tail=1, count becomes 15

      // 3: steady alloc+retire across the wrap
      for (int k = 0; k < 40; k++) begin
         step(0, 0, 1, 1, (2 + k) % 16);
         chk("wrap_grant", int'(bus.alloc_grant), 1);
         chk("wrap_idx",   int'(bus.alloc_idx), (1 + k) % 16);
         chk("wrap_count", int'(bus.count), 15);
         chk("wrap_err",   int'(bus.err), 0);
      end

      // 4: clear after five allocs
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0);
      step(0, 1, 1, 1, 0);
      chk("clr_pre_count", int'(bus.count), 5);
      chk("clr_grant", int'(bus.alloc_grant), 0);
      step(0, 0, 1, 0, 0);
      chk("clr_count", int'(bus.count), 0);
      chk("clr_empty", int'(bus.empty), 1);
      chk("clr_idx",   int'(bus.alloc_idx), 0);
      chk("clr_grant_next", int'(bus.alloc_grant), 1);
      chk("clr_err",   int'(bus.err), 0);
      step(0, 0, 0, 0, 0);
      chk("clr_count_after", int'(bus.count), 1);

      // 5: retire while empty
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0);
      chk("emp_count", int'(bus.count), 0);
      chk("emp_tail",  int'(bus.alloc_idx), 0);
      chk("emp_err",   int'(bus.err), 1);
      // alloc granted while empty cannot be retired in the same cycle
      step(0, 0, 1, 1, 0);
      chk("emp_grant", int'(bus.alloc_grant), 1);
      step(0, 1, 0, 0, 0);
      chk("emp_same_cyc_count", int'(bus.count), 1);
      step(0, 0, 0, 0, 0);
      chk("emp_err_after_clear", int'(bus.err), 1);
      chk("emp_count_after_clear", int'(bus.count), 0);
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("emp_err_after_rst", int'(bus.err), 0);

      // 6: out-of-order retire index
      for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 1);
      step(0, 0, 0, 0, 0);
      chk("ooo_pre_count", int'(bus.count), 2);
      chk("ooo_pre_err",   int'(bus.err), 0);
      step(0, 0, 0, 1, 3);
      step(0, 0, 0, 0, 0);
      chk("ooo_err",   int'(bus.err), 1);
      chk("ooo_count", int'(bus.count), 1);
      chk("ooo_tail",  int'(bus.alloc_idx), 4);
      step(0, 0, 0, 1, 3);
      step(0, 0, 0, 0, 0);
      chk("ooo_final_count", int'(bus.count), 0);
      chk("ooo_final_empty", int'(bus.empty), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
